// File: rtl/camera_cfg_sequencer.sv
// camera_cfg_sequencer: requests one camera pose per frame, stages it in a shadow bank, commits on new-frame.
module camera_cfg_sequencer #(
  parameter int W = 32,
  parameter int UNIT = 256,
  parameter int FOCAL_SHIFT = 7
) (
  input  logic             clk_in,
  input  logic             rst_n_in,
  input  logic             nf_in,
  input  logic             pose_valid_in,
  output logic             pose_ready_out,
  input  logic [9*W-1:0]   pose_in,
  output logic             pose_req_out,
  output logic [3*W-1:0]   cam_u_out,
  output logic [3*W-1:0]   cam_v_out,
  output logic [3*W-1:0]   cam_f_out,
  output logic             commit_out,
  output logic [15:0]      stale_cnt_out
);
  typedef enum logic [1:0] {S_REQ, S_WAIT, S_PEND} state_t;
  localparam int SW = W + 1 + FOCAL_SHIFT;
  localparam logic signed [SW-1:0] SMAX = $signed({{(FOCAL_SHIFT + 2){1'b0}}, {(W - 1){1'b1}}});
  localparam logic signed [SW-1:0] SMIN = $signed({{(FOCAL_SHIFT + 2){1'b1}}, {(W - 1){1'b0}}});
  localparam logic [3*W-1:0] ID_U = {W'(UNIT), W'(0), W'(0)};
  localparam logic [3*W-1:0] ID_V = {W'(0), W'(UNIT), W'(0)};
  // Negate at W+1 bits so -(-2^(W-1)) is representable before the clamp.
  function automatic logic [W-1:0] neg_scale(input logic [W-1:0] f);
    logic signed [W:0] n;
    logic signed [SW-1:0] s;
    n = -$signed({f[W-1], f});
    s = $signed({{FOCAL_SHIFT{n[W]}}, n}) <<< FOCAL_SHIFT;
    return (s > SMAX) ? {1'b0, {(W - 1){1'b1}}} : (s < SMIN) ? {1'b1, {(W - 1){1'b0}}} : s[W-1:0];
  endfunction
  state_t state;
  logic [3*W-1:0] sh_u, sh_v, sh_f;
  logic [3*W-1:0] id_f;
  assign id_f = {W'(0), W'(0), neg_scale(W'(UNIT))};
  assign pose_ready_out = state == S_WAIT;
  always_ff @(posedge clk_in) begin
    if (!rst_n_in) begin
      state <= S_REQ;
      pose_req_out <= 1'b0;
      commit_out <= 1'b0;
      stale_cnt_out <= 16'd0;
      sh_u <= ID_U;
      sh_v <= ID_V;
      sh_f <= id_f;
      cam_u_out <= ID_U;
      cam_v_out <= ID_V;
      cam_f_out <= id_f;
    end else begin
      pose_req_out <= state == S_REQ;
      commit_out <= 1'b0;
      if (nf_in && state != S_PEND)
        stale_cnt_out <= (stale_cnt_out == 16'hFFFF) ? stale_cnt_out : stale_cnt_out + 16'd1;
      case (state)
        S_REQ: state <= S_WAIT;
        S_WAIT: if (pose_valid_in) begin
          sh_u <= pose_in[9*W-1 -: 3*W];
          sh_v <= pose_in[6*W-1 -: 3*W];
          sh_f <= {neg_scale(pose_in[3*W-1 -: W]), neg_scale(pose_in[2*W-1 -: W]), neg_scale(pose_in[W-1:0])};
          state <= S_PEND;
        end
        S_PEND: if (nf_in) begin
          cam_u_out <= sh_u;
          cam_v_out <= sh_v;
          cam_f_out <= sh_f;
          commit_out <= 1'b1;
          stale_cnt_out <= 16'd0;
          state <= S_REQ;
        end
        default: state <= S_REQ;
      endcase
    end
  end
endmodule

// File: tb/tb_camera_cfg_sequencer.sv
// tb_camera_cfg_sequencer: directed and random frames checked against a pending/requested pose model.
module tb_camera_cfg_sequencer;
  logic clk_in = 0, rst_n_in = 0, nf_in = 0, pose_valid_in = 0;
  logic [287:0] pose_in = '0;
  logic pose_ready_out, pose_req_out, commit_out;
  logic [95:0] cam_u_out, cam_v_out, cam_f_out;
  logic [15:0] stale_cnt_out;
  int tests = 0, fails = 0;
  bit requested, pending, m_req, m_commit;
  int stale;
  logic [95:0] su, sv, sf, au, av, af;
  camera_cfg_sequencer dut (
    .clk_in(clk_in), .rst_n_in(rst_n_in), .nf_in(nf_in), .pose_valid_in(pose_valid_in),
    .pose_ready_out(pose_ready_out), .pose_in(pose_in), .pose_req_out(pose_req_out),
    .cam_u_out(cam_u_out), .cam_v_out(cam_v_out), .cam_f_out(cam_f_out),
    .commit_out(commit_out), .stale_cnt_out(stale_cnt_out));
  always #5 clk_in = ~clk_in;
  function automatic logic [31:0] mf(input logic [31:0] f);
    longint v;
    v = -longint'($signed(f)) * 128;
    if (v > 64'sd2147483647) v = 64'sd2147483647;
    if (v < -64'sd2147483648) v = -64'sd2147483648;
    return v[31:0];
  endfunction
  task automatic chk(input string tag, input logic [95:0] got, input logic [95:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic model_reset();
    requested = 0; pending = 0; m_req = 0; m_commit = 0; stale = 0;
    su = {32'd256, 64'd0}; sv = {32'd0, 32'd256, 32'd0}; sf = {64'd0, mf(32'd256)};
    au = su; av = sv; af = sf;
  endtask
  task automatic step(input bit rst, input bit nf, input bit valid, input logic [287:0] pose);
    bit ready;
    rst_n_in = rst; nf_in = nf; pose_valid_in = valid; pose_in = pose;
    @(posedge clk_in);
    if (!rst) model_reset();
    else begin
      ready = requested && !pending;
      m_req = !requested && !pending;
      m_commit = 0;
      if (nf && pending) begin
        au = su; av = sv; af = sf; m_commit = 1; stale = 0; pending = 0; requested = 0;
      end else begin
        if (nf) stale = (stale == 65535) ? stale : stale + 1;
        if (m_req) requested = 1;
        if (ready && valid) begin
          su = pose[287:192]; sv = pose[191:96];
          sf = {mf(pose[95:64]), mf(pose[63:32]), mf(pose[31:0])};
          pending = 1;
        end
      end
    end
    #1;
    chk("ready", 96'(pose_ready_out), 96'(requested && !pending));
    chk("req", 96'(pose_req_out), 96'(m_req));
    chk("commit", 96'(commit_out), 96'(m_commit));
    chk("stale", 96'(stale_cnt_out), 96'(stale));
    chk("cam_u", cam_u_out, au);
    chk("cam_v", cam_v_out, av);
    chk("cam_f", cam_f_out, af);
  endtask
  function automatic logic [31:0] rcomp();
    case ($urandom_range(0, 4))
      0: return 32'h80000000;
      1: return 32'h40000000;
      2: return 32'($signed($urandom_range(0, 2000)) - 1000);
      3: return 32'h0;
      default: return $urandom;
    endcase
  endfunction
  function automatic logic [287:0] rpose();
    logic [287:0] p;
    for (int i = 0; i < 9; i++) p[i*32 +: 32] = rcomp();
    return p;
  endfunction
  initial begin
    logic [287:0] p;
    model_reset();
    step(0, 0, 0, '0);
    step(0, 0, 0, '0);
    chk("rst_f_z", {64'd0, cam_f_out[31:0]}, {64'd0, 32'hFFFF8000});
    chk("rst_commit", 96'(commit_out), 96'd0);
    step(1, 0, 0, '0);
    chk("req_after_release", 96'(pose_req_out), 96'd1);
    p = rpose();
    p[95:0] = {32'd1, 32'd0, 32'd0};
    step(1, 0, 1, p);
    step(1, 1, 0, '0);
    chk("f_x_unit", {64'd0, cam_f_out[95:64]}, {64'd0, 32'hFFFFFF80});
    chk("u_match", cam_u_out, p[287:192]);
    chk("commit_pulse", 96'(commit_out), 96'd1);
    step(1, 0, 0, '0);
    step(1, 0, 0, '0);
    p = rpose();
    p[95:0] = {32'h80000000, 32'd0, 32'h40000000};
    step(1, 0, 1, p);
    step(1, 1, 0, '0);
    chk("f_x_clamp_max", {64'd0, cam_f_out[95:64]}, {64'd0, 32'h7FFFFFFF});
    chk("f_z_clamp_min", {64'd0, cam_f_out[31:0]}, {64'd0, 32'h80000000});
    for (int i = 0; i < 3; i++) step(1, 1, 0, '0);
    chk("stale_3", 96'(stale_cnt_out), 96'd3);
    step(1, 0, 1, rpose());
    step(1, 1, 0, '0);
    chk("stale_clear", 96'(stale_cnt_out), 96'd0);
    step(1, 0, 0, '0);
    step(1, 1, 1, rpose());
    chk("same_cycle_no_commit", 96'(commit_out), 96'd0);
    step(1, 0, 0, '0);
    chk("ready_low_pending", 96'(pose_ready_out), 96'd0);
    step(1, 1, 0, '0);
    chk("commit_next_nf", 96'(commit_out), 96'd1);
    step(1, 0, 0, '0);
    step(1, 0, 1, rpose());
    step(0, 0, 0, '0);
    chk("rst_pend_u", cam_u_out, {32'd256, 64'd0});
    step(1, 1, 0, '0);
    step(1, 1, 0, '0);
    step(1, 1, 0, '0);
    chk("pending_discarded", cam_f_out, {64'd0, 32'hFFFF8000});
    for (int i = 0; i < 3000; i++)
      step($urandom_range(0, 99) != 0, $urandom_range(0, 3) == 0, $urandom_range(0, 1) == 1, rpose());
    for (int i = 0; i < 65540; i++) step(1, 1, 0, '0);
    chk("stale_sat", 96'(stale_cnt_out), 96'h0FFFF);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
